// File: rtl/debug_print_pkg.sv
// Shared ASCII constants and formatter state encoding for the debug print path.
package debug_print_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_X  = 8'h78;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    PREFIX,
    DIGITS,
    CR,
    LF
  } state_t;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational nibble-to-ASCII hex digit converter, shared by debug printers.
module hex_nibble_to_ascii
  import debug_print_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       upper,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASCII_0 + {4'h0, nibble};
    if (nibble > 4'd9) begin
      ascii = (upper ? ASCII_UA : ASCII_LA) + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/uart_hex_printer.sv
// Streams a captured word as ASCII hex (MS nibble first) to uart_tx with valid/ready on both sides.
// Optional "0x" prefix is compiled in when UART_HEX_PRINTER_PREFIX_EN is defined.
module uart_hex_printer
  import debug_print_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter bit UPPERCASE   = 1'b1,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] value_i,
  input  logic                  value_valid_i,
  output logic                  value_ready_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_data_valid_o,
  input  logic                  tx_data_ready_i,
  output logic                  busy_o
);

  localparam int NUM_DIGITS = DATA_WIDTH / 4;
  localparam int CNT_W      = $clog2(NUM_DIGITS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] sr_reg, sr_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [7:0]            tx_data_reg, tx_data_next;
  logic                  tx_valid_reg, tx_valid_next;
  logic                  ready_reg, ready_next;
  logic                  busy_reg, busy_next;

  logic                  accept;
  logic                  tx_fire;
  logic [DATA_WIDTH-1:0] sr_shifted;
  logic [3:0]            nibble_sel;
  logic [7:0]            nibble_ascii;

  assign accept     = value_valid_i && ready_reg;
  assign tx_fire    = tx_valid_reg && tx_data_ready_i;
  assign sr_shifted = sr_reg << 4;

  // The converter always prepares the byte that follows the one on the bus.
  always_comb begin
    nibble_sel = sr_shifted[DATA_WIDTH-1 -: 4];
    if (state_reg == IDLE) begin
      nibble_sel = value_i[DATA_WIDTH-1 -: 4];
    end
`ifdef UART_HEX_PRINTER_PREFIX_EN
    if (state_reg == PREFIX) begin
      nibble_sel = sr_reg[DATA_WIDTH-1 -: 4];
    end
`endif
  end

  hex_nibble_to_ascii u_conv (
    .nibble (nibble_sel),
    .upper  (UPPERCASE),
    .ascii  (nibble_ascii)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      sr_reg       <= '0;
      cnt_reg      <= '0;
      tx_data_reg  <= 8'h00;
      tx_valid_reg <= 1'b0;
      ready_reg    <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sr_reg       <= sr_next;
      cnt_reg      <= cnt_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      ready_reg    <= ready_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    sr_next       = sr_reg;
    cnt_next      = cnt_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    ready_next    = ready_reg;
    busy_next     = busy_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          sr_next       = value_i;
          cnt_next      = '0;
          tx_valid_next = 1'b1;
          ready_next    = 1'b0;
          busy_next     = 1'b1;
`ifdef UART_HEX_PRINTER_PREFIX_EN
          state_next    = PREFIX;
          tx_data_next  = ASCII_0;
`else
          state_next    = DIGITS;
          tx_data_next  = nibble_ascii;
`endif
        end
      end
`ifdef UART_HEX_PRINTER_PREFIX_EN
      PREFIX: begin
        if (tx_fire) begin
          // The bus byte tells which half of "0x" is being sent.
          if (tx_data_reg == ASCII_0) begin
            tx_data_next = ASCII_X;
          end else begin
            state_next   = DIGITS;
            tx_data_next = nibble_ascii;
          end
        end
      end
`endif
      DIGITS: begin
        if (tx_fire) begin
          sr_next  = sr_shifted;
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_CNT) begin
            if (APPEND_CRLF) begin
              state_next   = CR;
              tx_data_next = ASCII_CR;
            end else begin
              state_next    = IDLE;
              tx_valid_next = 1'b0;
              ready_next    = 1'b1;
              busy_next     = 1'b0;
            end
          end else begin
            tx_data_next = nibble_ascii;
          end
        end
      end
      CR: begin
        if (tx_fire) begin
          state_next   = LF;
          tx_data_next = ASCII_LF;
        end
      end
      LF: begin
        if (tx_fire) begin
          state_next    = IDLE;
          tx_valid_next = 1'b0;
          ready_next    = 1'b1;
          busy_next     = 1'b0;
        end
      end
      default: begin
        state_next    = IDLE;
        tx_valid_next = 1'b0;
        ready_next    = 1'b1;
        busy_next     = 1'b0;
      end
    endcase
  end

  assign value_ready_o   = ready_reg;
  assign tx_data_o       = tx_data_reg;
  assign tx_data_valid_o = tx_valid_reg;
  assign busy_o          = busy_reg;

endmodule

// File: tb/tb_uart_hex_printer.sv
// Directed self-checking bench for uart_hex_printer (default and lowercase/no-CRLF builds).
module tb_uart_hex_printer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] value = 32'h0;
  logic        v_valid = 1'b0;
  logic        tx_ready = 1'b1;
  logic        sel = 1'b0;

  logic        valid_m, valid_l;
  logic        ready_m, ready_l;
  logic [7:0]  data_m, data_l;
  logic        txv_m, txv_l;
  logic        busy_m, busy_l;

  logic        o_ready, o_valid, o_busy;
  logic [7:0]  o_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign valid_m = v_valid & ~sel;
  assign valid_l = v_valid & sel;
  assign o_ready = sel ? ready_l : ready_m;
  assign o_valid = sel ? txv_l   : txv_m;
  assign o_busy  = sel ? busy_l  : busy_m;
  assign o_data  = sel ? data_l  : data_m;

  uart_hex_printer #(.DATA_WIDTH(32), .UPPERCASE(1'b1), .APPEND_CRLF(1'b1)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .value_i         (value),
    .value_valid_i   (valid_m),
    .value_ready_o   (ready_m),
    .tx_data_o       (data_m),
    .tx_data_valid_o (txv_m),
    .tx_data_ready_i (tx_ready),
    .busy_o          (busy_m)
  );

  uart_hex_printer #(.DATA_WIDTH(32), .UPPERCASE(1'b0), .APPEND_CRLF(1'b0)) dut_lc (
    .clk_i           (clk),
    .rst_i           (rst),
    .value_i         (value),
    .value_valid_i   (valid_l),
    .value_ready_o   (ready_l),
    .tx_data_o       (data_l),
    .tx_data_valid_o (txv_l),
    .tx_data_ready_i (tx_ready),
    .busy_o          (busy_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

`ifdef UART_HEX_PRINTER_PREFIX_EN
  localparam int PFX_LEN = 2;
  function automatic string pfx(input string s);
    return {"0x", s};
  endfunction
`else
  localparam int PFX_LEN = 0;
  function automatic string pfx(input string s);
    return s;
  endfunction
`endif

  // Called at a negedge with the selected printer idle. Optionally keeps
  // value_valid_i high with next_v to exercise back-to-back acceptance.
  task automatic print_word(input logic [31:0] v, input string exp,
                            input int stall_at, input int stall_len,
                            input bit keep, input logic [31:0] next_v);
    chk("ready_idle", 32'(o_ready), 32'd1);
    value   = v;
    v_valid = 1'b1;
    @(negedge clk);
    if (keep) value = next_v;
    else      v_valid = 1'b0;
    chk("busy_hi", 32'(o_busy), 32'd1);
    chk("ready_lo", 32'(o_ready), 32'd0);
    for (int i = 0; i < exp.len(); i++) begin
      if (i == stall_at) begin
        tx_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          chk("stall_data", 32'(o_data), 32'(exp[i]));
          chk("stall_valid", 32'(o_valid), 32'd1);
          @(negedge clk);
        end
        tx_ready = 1'b1;
      end
      chk("byte", 32'(o_data), 32'(exp[i]));
      chk("byte_valid", 32'(o_valid), 32'd1);
      @(negedge clk);
    end
    chk("end_valid", 32'(o_valid), 32'd0);
    chk("end_ready", 32'(o_ready), 32'd1);
    chk("end_busy", 32'(o_busy), 32'd0);
    $display("word %08h printed (%0d bytes), bad so far %0d", v, exp.len(), bad);
  endtask

  initial begin
    string e;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready_m), 32'd1);
    chk("rst_valid", 32'(txv_m), 32'd0);
    chk("rst_data", 32'(data_m), 32'h00);
    chk("rst_busy", 32'(busy_m), 32'd0);
    chk("rst_lc_valid", 32'(txv_l), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    print_word(32'hDEADBEEF, pfx("DEADBEEF\r\n"), -1, 0, 1'b0, 32'h0);
    print_word(32'h00000000, pfx("00000000\r\n"), -1, 0, 1'b0, 32'h0);
    print_word(32'h12345678, pfx("12345678\r\n"), PFX_LEN + 2, 5, 1'b0, 32'h0);

    // Held valid: second word must wait for the first to finish.
    print_word(32'h0000000A, pfx("0000000A\r\n"), -1, 0, 1'b1, 32'h000000FF);
    print_word(32'h000000FF, pfx("000000FF\r\n"), -1, 0, 1'b0, 32'h0);

    // Reset after the third byte abandons the string.
    e = pfx("CAFEF00D\r\n");
    value   = 32'hCAFEF00D;
    v_valid = 1'b1;
    @(negedge clk);
    v_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_seq_byte", 32'(o_data), 32'(e[i]));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_ready", 32'(o_ready), 32'd1);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_data", 32'(o_data), 32'h00);
    $display("word cafef00d aborted by reset after 3 bytes");
    print_word(32'h00000001, pfx("00000001\r\n"), -1, 0, 1'b0, 32'h0);

    sel = 1'b1;
    @(negedge clk);
    print_word(32'hABCDEF01, pfx("abcdef01"), -1, 0, 1'b0, 32'h0);
    repeat (3) begin
      chk("lc_no_crlf", 32'(o_valid), 32'd0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_hex_printer.md
Name: uart_hex_printer

Overview:
- Formats a parallel debug word (PC, DM register, last wishbone read value) as ASCII hexadecimal and streams it byte-by-byte into uart_tx.
- Sits between the debug producers (wishbone_dm_slave, wishbone_master, jtag_tap printf taps) and uart_tx.
- Replaces the send_data/printf/uart_controller path with a proper valid/ready handshake on both sides.

Parameters:
- DATA_WIDTH, 32, width of value_i; must be a multiple of 4; digits = DATA_WIDTH/4.
- UPPERCASE, 1, 1 selects 'A'-'F' (0x41-0x46); 0 selects 'a'-'f' (0x61-0x66).
- APPEND_CRLF, 1, 1 appends 0x0D 0x0A after the digits; 0 ends the string after the last digit.

Ports:
- clk_i  input  1  system clock (sys_clk, 27 MHz)
- rst_i  input  1  synchronous active-high reset
- value_i  input  DATA_WIDTH  word to print
- value_valid_i  input  1  producer offers value_i
- value_ready_o  output  1  printer can accept a word
- tx_data_o  output  8  ASCII byte to uart_tx
- tx_data_valid_o  output  1  tx_data_o is valid
- tx_data_ready_i  input  1  uart_tx accepts a byte
- busy_o  output  1  a word is being printed

Interface (already decided):
- One clock. Clock port is clk_i.
- Reset port is rst_i; it is synchronous and active-high.

Behaviour:
- Reset values: value_ready_o=1, tx_data_valid_o=0, tx_data_o=8'h00, busy_o=0, state=IDLE, digit counter=0.
- Handshakes:
  - Input: a word is accepted on a clock edge where value_valid_i && value_ready_o.
  - Output: a byte transfers on a clock edge where tx_data_valid_o && tx_data_ready_i.
  - All outputs are registered; there is no combinational path from an input to an output.
- Capture: on accept, value_i is latched into shift register sr. state goes to PREFIX or DIGITS. value_ready_o drops and busy_o rises on the next cycle.
- Latency: the first byte is presented with tx_data_valid_o=1 exactly 1 cycle after accept.
- States:
  - IDLE -> (accept) -> PREFIX (only if the optional feature is enabled) -> DIGITS -> CR -> LF -> IDLE.
  - With APPEND_CRLF=0, DIGITS goes directly to IDLE after the last digit.
  - Each state advances only on an output handshake.
- DIGITS:
  - Emits the most-significant nibble first.
  - Conversion: n<10 gives 0x30+n; n>=10 gives 0x41+n-10, or 0x61+n-10 when UPPERCASE=0.
  - On each handshake, sr shifts left by 4 and the counter increments. After DATA_WIDTH/4 digits the state leaves DIGITS.
  - Counter width is clog2(DATA_WIDTH/4)+1; it has no wrap-around.
- Backpressure: while tx_data_ready_i=0, tx_data_o and tx_data_valid_o hold stable. There is no limit on the stall length.
- Completion:
  - On the last byte's handshake, tx_data_valid_o=0 and the state is IDLE on the next cycle.
  - value_ready_o=1 and busy_o=0 on that same cycle.
  - Minimum gap between words: 1 IDLE cycle.
- value_valid_i held high while busy: ignored. The word is accepted in the first IDLE cycle with value_ready_o=1. No words are dropped and no words are duplicated.
- value_valid_i pulses while busy: lost. The producer must hold value_valid_i until value_ready_o is seen.
- value_i changing after accept: no effect on the current string.
- rst_i mid-string: on the next edge all outputs return to reset values and the partial string is abandoned. rst_i has priority over every handshake.
- Zero value: prints all DATA_WIDTH/4 digits; leading zeros are never suppressed.

Optional Feature:
- Macro: UART_HEX_PRINTER_PREFIX_EN.
- Defined: the PREFIX state emits "0x" (0x30, then 0x78) before the digits. Each prefix byte needs its own handshake.
- Undefined: the PREFIX state and its logic are not compiled; IDLE goes directly to DIGITS.

Decomposition:
- Package debug_print_pkg holds:
  - ASCII constants: ASCII_0=8'h30, ASCII_UA=8'h41, ASCII_LA=8'h61, ASCII_X=8'h78, ASCII_CR=8'h0D, ASCII_LF=8'h0A.
  - The state enum: IDLE, PREFIX, DIGITS, CR, LF.
- One natural sub-module: hex_nibble_to_ascii. It is purely combinational: 4-bit nibble plus UPPERCASE in, 8-bit ASCII out. It is reused by the formatter and future printers.

Test Plan:
- 0xDEADBEEF, ready tied 1 -> bytes 44 45 41 44 42 45 45 46 0D 0A on 10 consecutive cycles; first byte 1 cycle after accept; value_ready_o high 1 cycle after 0A.
- 0x00000000 with UART_HEX_PRINTER_PREFIX_EN defined -> 30 78 30 30 30 30 30 30 30 30 0D 0A.
- Backpressure: tx_data_ready_i low for 5 cycles during byte 3 of 0x12345678 -> tx_data_o=0x33 and valid held for all 5 cycles; sequence 31..38 0D 0A intact.
- Back-to-back: value_valid_i held with 0x0000000A, then 0x000000FF -> second word accepted only after the first 0A; output ...41 0D 0A then ...46 46 0D 0A.
- Parameters UPPERCASE=0, APPEND_CRLF=0: 0xABCDEF01 -> 61 62 63 64 65 66 30 31 only; no CR/LF.
- rst_i asserted for 1 cycle after the 3rd byte of 0xCAFEF00D -> next cycle tx_data_valid_o=0, value_ready_o=1, busy_o=0; a new word 0x1 then prints cleanly as 30 30 30 30 30 30 30 31 0D 0A.
